// File: rtl/bitwise_logic_pipe_if.sv
// rtl/bitwise_logic_pipe_if.sv - operand/result handshake bundle for bitwise_logic_pipe
// Optional parity signal present when BITWISE_LOGIC_PARITY_EN is defined.
interface bitwise_logic_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [CNT_W-1:0] beats;
`ifdef BITWISE_LOGIC_PARITY_EN
    logic             parity;
`endif

    modport slave (
        input  in_valid, a, b, op, acc, last, out_ready,
        output in_ready, out_valid, result, zero, beats
`ifdef BITWISE_LOGIC_PARITY_EN
        , output parity
`endif
    );

    modport master (
        output in_valid, a, b, op, acc, last, out_ready,
        input  in_ready, out_valid, result, zero, beats
`ifdef BITWISE_LOGIC_PARITY_EN
        , input parity
`endif
    );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// rtl/bitwise_logic_pipe.sv - registered 8-function bitwise unit with handshake and packet accumulate
// Optional registered parity output enabled by BITWISE_LOGIC_PARITY_EN.
module bitwise_logic_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    bitwise_logic_pipe_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] accum_q, accum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             out_valid_q, out_valid_d;
`ifdef BITWISE_LOGIC_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [CNT_W-1:0] load_beats;
    logic [WIDTH-1:0] fold;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [WIDTH-1:0] bit_fn(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        case (sel)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return ~(x & y);
            3'b011:  return ~(x | y);
            3'b100:  return x ^ y;
            3'b101:  return ~(x ^ y);
            3'b110:  return x;
            default: return ~x;
        endcase
    endfunction

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign fold         = bit_fn(bus.op, accum_q, bus.a);
    // Beat counter sticks at all-ones rather than wrapping.
    assign cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        accum_d    = accum_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        load_val   = '0;
        load_beats = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.acc) begin
                        load       = 1'b1;
                        load_val   = bit_fn(bus.op, bus.a, bus.b);
                        load_beats = CNT_W'(1);
                    end else if (!bus.last) begin
                        accum_d = bus.a;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end else begin
                        load       = 1'b1;
                        load_val   = bus.a;
                        load_beats = CNT_W'(1);
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (bus.last) begin
                        load       = 1'b1;
                        load_val   = fold;
                        load_beats = cnt_inc;
                        state_d    = IDLE;
                    end else begin
                        accum_d = fold;
                        cnt_d   = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A load in the same cycle as a transfer keeps out_valid high with no bubble.
    always_comb begin
        out_valid_d = load || (out_valid_q && !bus.out_ready);
        result_d    = load ? load_val : result_q;
        zero_d      = load ? (load_val == '0) : zero_q;
        beats_d     = load ? load_beats : beats_q;
`ifdef BITWISE_LOGIC_PARITY_EN
        parity_d    = load ? ^load_val : parity_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            accum_q     <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef BITWISE_LOGIC_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            accum_q     <= accum_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
`ifdef BITWISE_LOGIC_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.beats     = beats_q;
`ifdef BITWISE_LOGIC_PARITY_EN
    assign bus.parity    = parity_q;
`endif
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb/tb_bitwise_logic_pipe.sv - scoreboard bench for bitwise_logic_pipe (WIDTH=8, CNT_W=2)
module tb_bitwise_logic_pipe;
    localparam int W  = 8;
    localparam int CW = 2;

    typedef struct {
        logic [W-1:0]  result;
        logic          zero;
        logic [CW-1:0] beats;
        logic          parity;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    bitwise_logic_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    bitwise_logic_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ref_fn(input logic [2:0] sel, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        logic [W-1:0] r;
        case (sel)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = ~(x & y);
            3'd3: r = ~(x | y);
            3'd4: r = x ^ y;
            3'd5: r = ~(x ^ y);
            3'd6: r = x;
            default: r = ~x;
        endcase
        return r;
    endfunction

    function automatic void expect_out(input logic [W-1:0] r, input logic [CW-1:0] bt);
        exp_t e;
        e.result = r;
        e.zero   = (r == 0);
        e.beats  = bt;
        e.parity = ^r;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: output result=%h beats=%0d, required no output", bus.result, bus.beats);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.result !== e.result || bus.zero !== e.zero || bus.beats !== e.beats) begin
                    errors++;
                    $display("FAIL sb_output: got result=%h zero=%b beats=%0d, required result=%h zero=%b beats=%0d",
                             bus.result, bus.zero, bus.beats, e.result, e.zero, e.beats);
                end
`ifdef BITWISE_LOGIC_PARITY_EN
                checks++;
                if (bus.parity !== e.parity) begin
                    errors++;
                    $display("FAIL sb_parity: got %b, required %b", bus.parity, e.parity);
                end
`endif
            end
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] opv,
                        input logic accv, input logic lastv);
        bit ok;
        bus.a = av; bus.b = bv; bus.op = opv; bus.acc = accv; bus.last = lastv;
        bus.in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 8'h00 || bus.zero !== 1'b0 ||
            bus.beats !== 2'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got ov=%b res=%h zero=%b beats=%0d ir=%b, required 0 00 0 0 1",
                     bus.out_valid, bus.result, bus.zero, bus.beats, bus.in_ready);
        end
`ifdef BITWISE_LOGIC_PARITY_EN
        checks++;
        if (bus.parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity: got %b, required 0", bus.parity);
        end
`endif
    endtask

    task automatic test_single_ops();
        bus.out_ready = 1'b1;
        expect_out(8'h30, 2'd1);
        send(8'hF0, 8'h3C, 3'b000, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'h30) begin
            errors++;
            $display("FAIL latency: got ov=%b res=%h, required 1 30", bus.out_valid, bus.result);
        end
        expect_out(8'h00, 2'd1);
        send(8'hFF, 8'h00, 3'b011, 1'b0, 1'b0);
        expect_out(8'h00, 2'd1);
        send(8'hA5, 8'h5A, 3'b101, 1'b0, 1'b0);
        expect_out(8'hF0, 2'd1);
        send(8'h0F, 8'h00, 3'b111, 1'b0, 1'b0);
        expect_out(8'h5C, 2'd1);
        send(8'h5C, 8'h00, 3'b111, 1'b1, 1'b1);
    endtask

    task automatic test_random_ops();
        logic [W-1:0] av, bv;
        logic [2:0]   opv;
        for (int i = 0; i < 24; i++) begin
            av  = W'($urandom);
            bv  = W'($urandom);
            opv = 3'($urandom_range(0, 7));
            expect_out(ref_fn(opv, av, bv), 2'd1);
            send(av, bv, opv, 1'b0, 1'b0);
        end
    endtask

    task automatic test_accum_xor();
        send(8'h01, 8'h00, 3'b100, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL accum_quiet1: got ov=%b, required 0", bus.out_valid);
        end
        send(8'h02, 8'h00, 3'b100, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL accum_quiet2: got ov=%b, required 0", bus.out_valid);
        end
        expect_out(8'h07, 2'd3);
        send(8'h04, 8'h00, 3'b100, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'h07 || bus.beats !== 2'd3) begin
            errors++;
            $display("FAIL accum_xor: got ov=%b res=%h beats=%0d, required 1 07 3",
                     bus.out_valid, bus.result, bus.beats);
        end
        expect_out(8'hAB, 2'd3);
        send(8'hAB, 8'h00, 3'b110, 1'b1, 1'b0);
        send(8'h11, 8'h00, 3'b110, 1'b0, 1'b0);
        send(8'h22, 8'h00, 3'b110, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        logic [W-1:0] vals [6];
        vals = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
        expect_out(8'h3F, 2'd3);
        for (int i = 0; i < 6; i++)
            send(vals[i], 8'h00, 3'b001, (i == 0), (i == 5));
    endtask

    task automatic test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        expect_out(8'h30, 2'd1);
        send(8'hF0, 8'h3C, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 8'h30 || bus.beats !== 2'd1) begin
                errors++;
                $display("FAIL backpressure_hold: got ir=%b ov=%b res=%h beats=%0d, required 0 1 30 1",
                         bus.in_ready, bus.out_valid, bus.result, bus.beats);
            end
        end
        bus.out_ready = 1'b1;
        expect_out(8'hFF, 2'd1);
        send(8'h0F, 8'hF0, 3'b001, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'hFF) begin
            errors++;
            $display("FAIL no_bubble: got ov=%b res=%h, required 1 FF", bus.out_valid, bus.result);
        end
    endtask

    task automatic test_reset_mid_packet();
        send(8'h33, 8'h00, 3'b000, 1'b1, 1'b0);
        send(8'h55, 8'h00, 3'b000, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 8'h00 || bus.beats !== 2'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got ov=%b res=%h beats=%0d ir=%b, required 0 00 0 1",
                     bus.out_valid, bus.result, bus.beats, bus.in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_out(8'h01, 2'd1);
        send(8'h11, 8'h01, 3'b000, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'h01 || bus.beats !== 2'd1) begin
            errors++;
            $display("FAIL after_reset: got ov=%b res=%h beats=%0d, required 1 01 1",
                     bus.out_valid, bus.result, bus.beats);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 3'b000;
        bus.acc       = 1'b0;
        bus.last      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_single_ops();
        test_random_ops();
        test_accum_xor();
        test_saturation();
        test_back_to_back();
        test_reset_mid_packet();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d outputs still pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
